// File: rtl/btn_pkg.sv
// Shared encodings for the push-button debouncer: channel FSM states and counter widths.
package btn_pkg;

  localparam int CNT_W = 4;
  localparam int RPT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } state_t;

endpackage

// File: rtl/btn_debounce_if.sv
// Debouncer bus: divider count and raw buttons toward the debouncer, filtered levels and pulses back.
interface btn_debounce_if
  import btn_pkg::*;
#(
  parameter int N = 4
);
  logic [15:0]  clkdiv_in;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  modport master (
    output clkdiv_in,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  clkdiv_in,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, tick-driven accept/reject FSM, registered level/pulses.
// BTN_AUTOREPEAT_EN adds a repeat counter that re-pulses btn_press while the button stays held.
module btn_chan
  import btn_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int ACTIVE_LOW = 0
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DLY = 32,
  parameter int REPEAT_PER = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);
  localparam logic             INV      = 1'(ACTIVE_LOW != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             s;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] DLY_V = RPT_W'(REPEAT_DLY);
  localparam logic [RPT_W-1:0] PER_V = RPT_W'(REPEAT_PER);

  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
  logic             rpt_again_q, rpt_again_d;
`endif

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    s         = sync2_q ^ INV;
    cnt_inc   = (cnt_q < STABLE_V) ? cnt_q + CNT_W'(1) : cnt_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (s) begin
            cnt_d = CNT_W'(1);
            if (STABLE_CNT == 1) begin
              state_d = ST_PRESSED;
              press_d = 1'b1;
            end else begin
              state_d = ST_PRESS_WAIT;
            end
          end
        end
        ST_PRESS_WAIT: begin
          if (s) begin
            cnt_d = cnt_inc;
            if (cnt_inc == STABLE_V) begin
              state_d = ST_PRESSED;
              press_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (!s) begin
            cnt_d = CNT_W'(1);
            if (STABLE_CNT == 1) begin
              state_d   = ST_IDLE;
              release_d = 1'b1;
            end else begin
              state_d = ST_RELEASE_WAIT;
            end
          end
        end
        ST_RELEASE_WAIT: begin
          if (!s) begin
            cnt_d = cnt_inc;
            if (cnt_inc == STABLE_V) begin
              state_d   = ST_IDLE;
              release_d = 1'b1;
            end
          end else begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
      endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    // Counter only advances on ticks spent wholly inside PRESSED; any exit restarts the delay.
    rpt_d       = rpt_q;
    rpt_again_d = rpt_again_q;
    rpt_inc     = rpt_q + RPT_W'(1);
    if (state_d != ST_PRESSED) begin
      rpt_d       = '0;
      rpt_again_d = 1'b0;
    end else if (tick && (state_q == ST_PRESSED)) begin
      if (rpt_inc == (rpt_again_q ? PER_V : DLY_V)) begin
        press_d     = 1'b1;
        rpt_d       = '0;
        rpt_again_d = 1'b1;
      end else begin
        rpt_d = rpt_inc;
      end
    end
`endif

    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q       <= '0;
      rpt_again_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_again_q <= rpt_again_d;
    end
  end
`endif

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel debouncer: sample tick from a rising edge of one divider bit, N independent channels.
// Define BTN_AUTOREPEAT_EN to enable held-button auto-repeat on btn_press.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N          = 4,
  parameter int SAMPLE_BIT = 15,
  parameter int STABLE_CNT = 4,
  parameter int ACTIVE_LOW = 0,
  parameter int REPEAT_DLY = 32,
  parameter int REPEAT_PER = 8
) (
  input logic          clk,
  input logic          rst,
  btn_debounce_if.slave bus
);

  if ((STABLE_CNT < 1) || (STABLE_CNT > (1 << CNT_W) - 1) ||
      (REPEAT_DLY < 1) || (REPEAT_DLY > (1 << RPT_W) - 1) ||
      (REPEAT_PER < 1) || (REPEAT_PER > (1 << RPT_W) - 1)) begin : g_bad_param
    $error("btn_debounce: parameter out of range");
  end

  logic         tick_prev_q, tick_prev_d;
  logic         tick;
  logic [N-1:0] level_w, press_w, release_w;
  logic         unused_clkdiv;

  // Only the selected divider bit matters; the wrap to zero is a falling edge and never ticks.
  always_comb tick_prev_d = bus.clkdiv_in[SAMPLE_BIT];
  assign tick          = bus.clkdiv_in[SAMPLE_BIT] & ~tick_prev_q;
  assign unused_clkdiv = ^bus.clkdiv_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_prev_q <= 1'b0;
    else     tick_prev_q <= tick_prev_d;
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    btn_chan #(
      .STABLE_CNT (STABLE_CNT),
      .ACTIVE_LOW (ACTIVE_LOW)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
`endif
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .btn_raw     (bus.btn_raw[i]),
      .btn_level   (level_w[i]),
      .btn_press   (press_w[i]),
      .btn_release (release_w[i])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: two instances (active-high and active-low) checked cycle by cycle
// against a run-length reference model of the accept/reject rules.
module tb_btn_debounce;
  localparam int N      = 4;
  localparam int SB     = 2;
  localparam int STABLE = 4;
  localparam int RDLY   = 4;
  localparam int RPER   = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  cd;
  logic [N-1:0] raw [2];
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  // Divider under reset, as in the lab system.
  always @(posedge clk or posedge rst) begin
    if (rst) cd <= '0;
    else     cd <= cd + 16'd1;
  end

  btn_debounce_if #(.N(N)) if0 ();
  btn_debounce_if #(.N(N)) if1 ();
  assign if0.clkdiv_in = cd;
  assign if1.clkdiv_in = cd;
  assign if0.btn_raw   = raw[0];
  assign if1.btn_raw   = raw[1];

  btn_debounce #(.N(N), .SAMPLE_BIT(SB), .STABLE_CNT(STABLE), .ACTIVE_LOW(0),
                 .REPEAT_DLY(RDLY), .REPEAT_PER(RPER))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  btn_debounce #(.N(N), .SAMPLE_BIT(SB), .STABLE_CNT(STABLE), .ACTIVE_LOW(1),
                 .REPEAT_DLY(RDLY), .REPEAT_PER(RPER))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // Reference model: a channel flips its accepted level after STABLE consecutive tick samples
  // that disagree with it; an agreeing sample resets the run.
  logic [N-1:0] m_level [2];
  logic [N-1:0] m_press [2];
  logic [N-1:0] m_release [2];
  logic [N-1:0] m_sh1 [2];
  logic [N-1:0] m_sh2 [2];
  int           m_run [2][N];
`ifdef BTN_AUTOREPEAT_EN
  int           m_held [2][N];
`endif
  logic         m_prev;
  logic         m_tick;

  always @(posedge clk or posedge rst) begin : model
    logic t;
    logic s;
    if (rst) begin
      m_prev = 1'b0;
      m_tick = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_level[k] = '0; m_press[k] = '0; m_release[k] = '0;
        m_sh1[k] = '0; m_sh2[k] = '0;
        for (int i = 0; i < N; i++) begin
          m_run[k][i] = 0;
`ifdef BTN_AUTOREPEAT_EN
          m_held[k][i] = 0;
`endif
        end
      end
    end else begin
      t      = cd[SB] && !m_prev;
      m_prev = cd[SB];
      m_tick = t;
      for (int k = 0; k < 2; k++) begin
        m_press[k]   = '0;
        m_release[k] = '0;
        for (int i = 0; i < N; i++) begin
          s = m_sh2[k][i] ^ (k == 1);
          if (t) begin
            if (s != m_level[k][i]) begin
`ifdef BTN_AUTOREPEAT_EN
              m_held[k][i] = 0;
`endif
              m_run[k][i] = m_run[k][i] + 1;
              if (m_run[k][i] >= STABLE) begin
                m_level[k][i] = s;
                m_run[k][i]   = 0;
                if (s) m_press[k][i] = 1'b1;
                else   m_release[k][i] = 1'b1;
              end
            end else begin
`ifdef BTN_AUTOREPEAT_EN
              if (s && m_run[k][i] == 0) begin
                m_held[k][i] = m_held[k][i] + 1;
                if (m_held[k][i] == RDLY ||
                    (m_held[k][i] > RDLY && (m_held[k][i] - RDLY) % RPER == 0))
                  m_press[k][i] = 1'b1;
              end
`endif
              m_run[k][i] = 0;
            end
          end
        end
        m_sh2[k] = m_sh1[k];
        m_sh1[k] = raw[k];
      end
    end
  end

  task test_reset;
    rst    = 1'b1;
    raw[0] = '0;
    raw[1] = '1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({if0.btn_level, if0.btn_press, if0.btn_release} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_dut0: got %h required 000", {if0.btn_level, if0.btn_press, if0.btn_release});
    end
    n_cmp++;
    if ({if1.btn_level, if1.btn_press, if1.btn_release} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_dut1: got %h required 000", {if1.btn_level, if1.btn_press, if1.btn_release});
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({if0.btn_level, if0.btn_press, if0.btn_release} !== 12'h000) begin
        n_err++;
        $display("FAIL post_reset_idle cyc %0d: got %h required 000", c,
                 {if0.btn_level, if0.btn_press, if0.btn_release});
      end
    end
  endtask

  task test_clean_press;
    int presses, pw, maxw, rise;
    presses = 0; pw = 0; maxw = 0; rise = -1;
    raw[0][0] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({if0.btn_level, if0.btn_press, if0.btn_release} !== {m_level[0], m_press[0], m_release[0]}) begin
        n_err++;
        $display("FAIL clean_press_model cyc %0d: got %h required %h", c,
                 {if0.btn_level, if0.btn_press, if0.btn_release}, {m_level[0], m_press[0], m_release[0]});
      end
      if (if0.btn_press[0]) begin presses++; pw++; if (pw > maxw) maxw = pw; end
      else pw = 0;
      if (if0.btn_level[0] && rise < 0) rise = c + 1;
    end
    n_cmp++;
    if (presses !== 1) begin n_err++; $display("FAIL clean_press_count: got %0d required 1", presses); end
    n_cmp++;
    if (maxw !== 1) begin n_err++; $display("FAIL clean_press_width: got %0d required 1", maxw); end
    n_cmp++;
    if (rise < 2 + (STABLE - 1) * 8 || rise > 2 + STABLE * 8 + 1) begin
      n_err++;
      $display("FAIL clean_press_latency: got %0d required %0d..%0d", rise, 2 + (STABLE - 1) * 8, 2 + STABLE * 8 + 1);
    end
    n_cmp++;
    if (if0.btn_level !== 4'b0001) begin
      n_err++;
      $display("FAIL clean_press_level: got %b required 0001", if0.btn_level);
    end
  endtask

  task test_release;
    int rels, presses, rw, maxw;
    rels = 0; presses = 0; rw = 0; maxw = 0;
    raw[0][0] = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({if0.btn_level, if0.btn_press, if0.btn_release} !== {m_level[0], m_press[0], m_release[0]}) begin
        n_err++;
        $display("FAIL release_model cyc %0d: got %h required %h", c,
                 {if0.btn_level, if0.btn_press, if0.btn_release}, {m_level[0], m_press[0], m_release[0]});
      end
      if (if0.btn_release[0]) begin rels++; rw++; if (rw > maxw) maxw = rw; end
      else rw = 0;
      if (if0.btn_press[0]) presses++;
    end
    n_cmp++;
    if (rels !== 1 || maxw !== 1) begin
      n_err++;
      $display("FAIL release_pulse: got count %0d width %0d required 1/1", rels, maxw);
    end
    n_cmp++;
    if (presses !== 0) begin n_err++; $display("FAIL release_no_press: got %0d required 0", presses); end
    n_cmp++;
    if (if0.btn_level !== 4'b0000) begin n_err++; $display("FAIL release_level: got %b required 0000", if0.btn_level); end
  endtask

  task test_bounce;
    int activity;
    activity = 0;
    for (int c = 0; c < 110; c++) begin
      raw[0][1] = (c < 60) ? ((c / 5) % 2 == 0) : 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({if0.btn_level, if0.btn_press, if0.btn_release} !== {m_level[0], m_press[0], m_release[0]}) begin
        n_err++;
        $display("FAIL bounce_model cyc %0d: got %h required %h", c,
                 {if0.btn_level, if0.btn_press, if0.btn_release}, {m_level[0], m_press[0], m_release[0]});
      end
      if (if0.btn_level[1] || if0.btn_press[1] || if0.btn_release[1]) activity++;
    end
    n_cmp++;
    if (activity !== 0) begin n_err++; $display("FAIL bounce_rejected: got %0d active cycles required 0", activity); end
  endtask

  task test_reset_mid_wait;
    int  ticks, waited;
    bit  seen;
    raw[0][3] = 1'b1;
    repeat (60) @(negedge clk);
    raw[0][2] = 1'b1;
    waited = 0;
    while (m_run[0][2] != 3 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (waited >= 200) begin n_err++; $display("FAIL midwait_reach_cnt3: got timeout required cnt 3"); end
    n_cmp++;
    if (if0.btn_level !== 4'b1000) begin
      n_err++;
      $display("FAIL midwait_pre_reset_level: got %b required 1000", if0.btn_level);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({if0.btn_level, if0.btn_press, if0.btn_release, if1.btn_level, if1.btn_press, if1.btn_release} !== 24'h0) begin
      n_err++;
      $display("FAIL midwait_reset_zero: got %h/%h required 000/000",
               {if0.btn_level, if0.btn_press, if0.btn_release}, {if1.btn_level, if1.btn_press, if1.btn_release});
    end
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    ticks = 0;
    seen  = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({if0.btn_level, if0.btn_press, if0.btn_release} !== {m_level[0], m_press[0], m_release[0]}) begin
        n_err++;
        $display("FAIL midwait_model cyc %0d: got %h required %h", c,
                 {if0.btn_level, if0.btn_press, if0.btn_release}, {m_level[0], m_press[0], m_release[0]});
      end
      if (m_tick) ticks++;
      if (if0.btn_level[2] && !seen) begin
        seen = 1'b1;
        n_cmp++;
        if (ticks !== STABLE) begin
          n_err++;
          $display("FAIL midwait_fresh_ticks: got %0d required %0d", ticks, STABLE);
        end
      end
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL midwait_accept: got no level rise required rise"); end
  endtask

  task test_active_low;
    int presses;
    presses = 0;
    raw[0] = '0;
    raw[1] = 4'hF;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({if1.btn_level, if1.btn_press, if1.btn_release} !== 12'h000) begin
        n_err++;
        $display("FAIL active_low_idle cyc %0d: got %h required 000", c,
                 {if1.btn_level, if1.btn_press, if1.btn_release});
      end
    end
    raw[1] = 4'hE;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({if1.btn_level, if1.btn_press, if1.btn_release} !== {m_level[1], m_press[1], m_release[1]}) begin
        n_err++;
        $display("FAIL active_low_model cyc %0d: got %h required %h", c,
                 {if1.btn_level, if1.btn_press, if1.btn_release}, {m_level[1], m_press[1], m_release[1]});
      end
      if (if1.btn_press !== 4'b0000) presses++;
    end
    n_cmp++;
    if (if1.btn_level !== 4'b0001 || presses !== 1) begin
      n_err++;
      $display("FAIL active_low_ch0: got level %b presses %0d required 0001/1", if1.btn_level, presses);
    end
  endtask

  task test_random;
    int hold [2][N];
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) hold[k][i] = $urandom_range(1, 40);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({if0.btn_level, if0.btn_press, if0.btn_release} !== {m_level[0], m_press[0], m_release[0]}) begin
        n_err++;
        $display("FAIL random_dut0 cyc %0d: got %h required %h", c,
                 {if0.btn_level, if0.btn_press, if0.btn_release}, {m_level[0], m_press[0], m_release[0]});
      end
      n_cmp++;
      if ({if1.btn_level, if1.btn_press, if1.btn_release} !== {m_level[1], m_press[1], m_release[1]}) begin
        n_err++;
        $display("FAIL random_dut1 cyc %0d: got %h required %h", c,
                 {if1.btn_level, if1.btn_press, if1.btn_release}, {m_level[1], m_press[1], m_release[1]});
      end
      n_cmp++;
      if (((if0.btn_press & if0.btn_release) | (if1.btn_press & if1.btn_release)) !== 4'b0000) begin
        n_err++;
        $display("FAIL random_press_release_excl cyc %0d: got %b/%b required 0000", c,
                 if0.btn_press & if0.btn_release, if1.btn_press & if1.btn_release);
      end
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < N; i++) begin
          if (hold[k][i] == 0) begin
            raw[k][i]  = ~raw[k][i];
            hold[k][i] = ($urandom_range(0, 2) == 0) ? $urandom_range(25, 70) : $urandom_range(1, 6);
          end else begin
            hold[k][i] = hold[k][i] - 1;
          end
        end
    end
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task test_autorepeat;
    int dut_presses, exp_presses;
    dut_presses = 0; exp_presses = 0;
    raw[0] = '0;
    repeat (60) @(negedge clk);
    raw[0][2] = 1'b1;
    for (int c = 0; c < 210; c++) begin
      if (c == 150) raw[0][2] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({if0.btn_level, if0.btn_press, if0.btn_release} !== {m_level[0], m_press[0], m_release[0]}) begin
        n_err++;
        $display("FAIL autorepeat_model cyc %0d: got %h required %h", c,
                 {if0.btn_level, if0.btn_press, if0.btn_release}, {m_level[0], m_press[0], m_release[0]});
      end
      if (if0.btn_press[2]) dut_presses++;
      if (m_press[0][2]) exp_presses++;
    end
    n_cmp++;
    if (dut_presses !== exp_presses || exp_presses < 3) begin
      n_err++;
      $display("FAIL autorepeat_count: got %0d required %0d (at least 3)", dut_presses, exp_presses);
    end
  endtask
`endif

  initial begin
    raw[0] = '0;
    raw[1] = '1;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid_wait();
    test_active_low();
    test_random();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
